// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// WIDTH iterations per operation, product held after the done pulse.
module seq_mult #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] b_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [PW-1:0]    prod_next;

    // State, operand, counter and product registers; flags mirror the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            a_r     <= a_next;
            b_r     <= b_next;
            cnt     <= cnt_next;
            product <= prod_next;
            busy    <= (state_next == ST_RUN);
            done    <= (state_next == ST_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        a_next     = a_r;
        b_next     = b_r;
        cnt_next   = cnt;
        prod_next  = product;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    cnt_next   = '0;
                    prod_next  = '0;
                    state_next = ST_RUN;
                end else if (state == ST_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (b_r[0]) begin
                    prod_next = product + (PW'(a_r) << cnt);
                end
                b_next = b_r >> 1;
                // Counter parks on its last value rather than stepping past WIDTH-1
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential unsigned shift-and-add multiplier; successor to the 2-bit gate-level combinational multiplier.
- Accepts two WIDTH-bit operands on a start pulse and computes one partial product per cycle.
- Presents a 2*WIDTH-bit product with a done pulse. The product is held until the next operation.
- Sits on a datapath that can trade latency for area, such as lab ALU or MAC stages.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32); the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising edge of clk.
- a  input  WIDTH  multiplicand; sampled only when start is accepted.
- b  input  WIDTH  multiplier; sampled only when start is accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  2*WIDTH  result register.

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE, product=0, done=0, busy=0, and internal count/operand registers=0.
- rst has priority over every other input.
- Reset mid-operation abandons the operation; no done pulse is issued for it.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 -> latch A_r=a, B_r=b; clear product to 0; count=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN, each edge:
  - If B_r[0]=1, product <= product + (zero-extended A_r << count); otherwise product is unchanged.
  - B_r <= B_r >> 1; count <= count+1.
  - On the edge where count==WIDTH-1 the last iteration is done; go to DONE.
- Exactly WIDTH RUN edges per operation; no early termination when B_r becomes zero.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 -> accept the new operands as in IDLE and go to RUN (back-to-back operation).
  - start=0 -> go to IDLE.
- Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH. The product is final from edge WIDTH onward.
- Throughput: one result per WIDTH+1 cycles with start held high continuously.
- busy = (state==RUN). It is registered or decoded from state with no combinational path from start.
- done = (state==DONE).
- start in RUN is ignored: no restart, and operands are not re-latched.
- a and b may change freely after acceptance without affecting the result.
- product:
  - Cleared to 0 at acceptance, so it is meaningless while busy=1.
  - After done it holds its value indefinitely in IDLE until the next accepted start.
- Arithmetic is unsigned. The 2*WIDTH accumulator cannot overflow, since max (2^W-1)^2 < 2^(2W).
- count is ceil(log2(WIDTH))+1 bits wide and stops at WIDTH-1 with no wrap inside an operation.
- Fully synchronous: no latches and no gated clocks.

Test Plan:
- WIDTH=4; rst for 2 cycles, then start with a=3, b=3 -> busy high for 4 cycles; done pulses for 1 cycle 4 cycles after the start edge; product=9, still 9 ten cycles later.
- WIDTH=4; a=15, b=15 -> product=225 (0xE1); then a=0, b=13 -> product=0, with done still asserted after exactly 4 RUN cycles.
- WIDTH=4; a=5, b=6, then pulse start with a=9, b=9 during RUN cycle 2 -> the second start is ignored; product=30; exactly one done pulse.
- WIDTH=4; start held high continuously with a=7, b=2 -> done every 5 cycles; product=14 at each done; busy low only during the DONE cycles.
- WIDTH=4; a=11, b=11, assert rst on RUN cycle 2 -> next cycle product=0, busy=0, done=0, state IDLE; no done ever appears for that operation. A following a=2, b=3 then yields product=6.
- WIDTH=8; a=255, b=255 -> product=65025 (0xFE01) after 8 RUN cycles. Also check a=128, b=2 -> product=256.
